// File: rtl/blink_meter_if.sv
// Measurement bus of the blink meter: the raw pin going in and the
// measured durations, edge rate and stall status coming out.
interface blink_meter_if #(
  parameter int CNT_W  = 24,
  parameter int RATE_W = 16
);
  logic              blink_in;
  logic [CNT_W-1:0]  high_time;
  logic [CNT_W-1:0]  low_time;
  logic [CNT_W:0]    period;
  logic              meas_valid;
  logic [RATE_W-1:0] edge_rate;
  logic              rate_valid;
  logic              stalled;
  logic              stuck_level;

  // Meter side: consumes the pin, produces the measurements.
  modport master (
    input  blink_in,
    output high_time, low_time, period, meas_valid,
    output edge_rate, rate_valid, stalled, stuck_level
  );

  // Status/debug side: drives the pin, reads the measurements.
  modport slave (
    output blink_in,
    input  high_time, low_time, period, meas_valid,
    input  edge_rate, rate_valid, stalled, stuck_level
  );
endinterface

// File: rtl/blink_meter.sv
// Blink meter: synchronises and glitch-filters an external blink signal,
// measures high/low time and period of each full cycle, counts rising edges
// per CLK_HZ window and flags an input that stops toggling.
module blink_meter #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int CNT_W   = 24,
  parameter int GLITCH  = 4,
  parameter int TIMEOUT = 25_000_000,
  parameter int RATE_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  blink_meter_if.master mif
);

  localparam int WIN_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RUN_W = $clog2(GLITCH + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_HZ - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(GLITCH - 1);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STALL} state_t;

  state_t            state, state_nxt;
  logic              sync_p0, sync_p1;
  logic              filt, filt_prev;
  logic [RUN_W-1:0]  run;
  logic [CNT_W-1:0]  hcnt, lcnt, hcnt_nxt, lcnt_nxt;
  logic              publish, stall_set, stall_clr;
  logic              rise, fall;
  logic [WIN_W-1:0]  wcnt;
  logic [RATE_W-1:0] ecnt;

  // Duration counters hold at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    cnt_sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Edge counter holds at full scale instead of wrapping.
  function automatic logic [RATE_W-1:0] rate_sat_add(input logic [RATE_W-1:0] v,
                                                     input logic inc);
    rate_sat_add = (inc && (v != {RATE_W{1'b1}})) ? v + RATE_W'(1) : v;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= mif.blink_in;
      sync_p1 <= sync_p0;
    end
  end

  // Glitch filter: accept a new level only after GLITCH consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt      <= 1'b0;
      filt_prev <= 1'b0;
      run       <= '0;
    end else begin
      filt_prev <= filt;
      if (sync_p1 != filt) begin
        if (run == RUN_LAST) begin
          filt <= sync_p1;
          run  <= '0;
        end else begin
          run <= run + RUN_W'(1);
        end
      end else begin
        run <= '0;
      end
    end
  end

  assign rise = filt & ~filt_prev;
  assign fall = ~filt & filt_prev;

  // Measurement FSM: next state, counter updates and publish/stall strobes.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    lcnt_nxt  = lcnt;
    publish   = 1'b0;
    stall_set = 1'b0;
    stall_clr = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          hcnt_nxt  = CNT_W'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
          lcnt_nxt  = CNT_W'(1);
        end else if (hcnt == TO_CNT) begin
          state_nxt = STALL;
          stall_set = 1'b1;
        end else begin
          hcnt_nxt = cnt_sat_inc(hcnt);
        end
      end
      LOW: begin
        // A rise wins over a coincident timeout.
        if (rise) begin
          state_nxt = HIGH;
          hcnt_nxt  = CNT_W'(1);
          publish   = 1'b1;
        end else if (lcnt == TO_CNT) begin
          state_nxt = STALL;
          stall_set = 1'b1;
        end else begin
          lcnt_nxt = cnt_sat_inc(lcnt);
        end
      end
      STALL: begin
        // Leaving a stall restarts measurement; nothing is published.
        if (rise) begin
          state_nxt = HIGH;
          hcnt_nxt  = CNT_W'(1);
          stall_clr = 1'b1;
        end else if (fall) begin
          state_nxt = IDLE;
          stall_clr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Measurement FSM state, counters and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      hcnt            <= '0;
      lcnt            <= '0;
      mif.high_time   <= '0;
      mif.low_time    <= '0;
      mif.period      <= '0;
      mif.meas_valid  <= 1'b0;
      mif.stalled     <= 1'b0;
      mif.stuck_level <= 1'b0;
    end else begin
      state          <= state_nxt;
      hcnt           <= hcnt_nxt;
      lcnt           <= lcnt_nxt;
      mif.meas_valid <= publish;
      if (publish) begin
        mif.high_time <= hcnt;
        mif.low_time  <= lcnt;
        mif.period    <= {1'b0, hcnt} + {1'b0, lcnt};
      end
      if (stall_set) begin
        mif.stalled     <= 1'b1;
        mif.stuck_level <= filt;
      end else if (stall_clr) begin
        mif.stalled <= 1'b0;
      end
    end
  end

  // Rate window: count filtered rises, report and restart every CLK_HZ cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt           <= '0;
      ecnt           <= '0;
      mif.edge_rate  <= '0;
      mif.rate_valid <= 1'b0;
    end else if (wcnt == WIN_LAST) begin
      wcnt           <= '0;
      mif.edge_rate  <= rate_sat_add(ecnt, rise);
      ecnt           <= '0;
      mif.rate_valid <= 1'b1;
    end else begin
      wcnt           <= wcnt + WIN_W'(1);
      ecnt           <= rate_sat_add(ecnt, rise);
      mif.rate_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// Bench for blink_meter: table of square waves with hand-derived results,
// directed glitch/stall/reset sequences, and random pulse trains checked
// every cycle against a timestamp-based reference model.
module tb_blink_meter;
  localparam int CLK_HZ  = 1000;
  localparam int CNT_W   = 12;
  localparam int GLITCH  = 4;
  localparam int TIMEOUT = 500;
  localparam int RATE_W  = 16;

  localparam int P_IDLE = 0, P_HIGH = 1, P_LOW = 2, P_STALL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  blink_meter_if #(.CNT_W(CNT_W), .RATE_W(RATE_W)) mif ();

  blink_meter #(
    .CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .GLITCH(GLITCH),
    .TIMEOUT(TIMEOUT), .RATE_W(RATE_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mif(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tk = 0;
  int mv_seen = 0;

  // Reference model: filtered level from the last GLITCH synchronised
  // samples, durations from edge timestamps.
  int n;
  bit raw_q[$];
  bit sin_q[$];
  bit mf, mf_prev;
  int ph, t_start, t_low, h_meas, ecount;
  int e_high, e_low, e_period, e_rate;
  bit e_mv, e_rv, e_st, e_sl;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_high;
    int exp_low;
    int exp_period;
    int exp_pulses;
  } vec_t;
  vec_t tbl[5];

  task automatic model_reset();
    n = 0;
    raw_q.delete();
    raw_q.push_back(1'b0);
    raw_q.push_back(1'b0);
    sin_q.delete();
    mf = 0; mf_prev = 0;
    ph = P_IDLE; t_start = 0; t_low = 0; h_meas = 0; ecount = 0;
    e_high = 0; e_low = 0; e_period = 0; e_rate = 0;
    e_mv = 0; e_rv = 0; e_st = 0; e_sl = 0;
  endtask

  task automatic model_edge(input bit b);
    bit rise, fall, sv, flip;
    n++;
    rise = mf && !mf_prev;
    fall = !mf && mf_prev;
    e_mv = 0;
    e_rv = 0;
    case (ph)
      P_IDLE: if (rise) begin ph = P_HIGH; t_start = n; end
      P_HIGH: begin
        if (fall) begin
          h_meas = n - t_start; ph = P_LOW; t_low = n;
        end else if (n - t_start == TIMEOUT) begin
          ph = P_STALL; e_st = 1; e_sl = mf;
        end
      end
      P_LOW: begin
        if (rise) begin
          e_high = h_meas; e_low = n - t_low; e_period = e_high + e_low;
          e_mv = 1; ph = P_HIGH; t_start = n;
        end else if (n - t_low == TIMEOUT) begin
          ph = P_STALL; e_st = 1; e_sl = mf;
        end
      end
      default: begin
        if (rise) begin ph = P_HIGH; t_start = n; e_st = 0; end
        else if (fall) begin ph = P_IDLE; e_st = 0; end
      end
    endcase
    if (rise && ecount < (1 << RATE_W) - 1) ecount++;
    if (n % CLK_HZ == 0) begin
      e_rate = ecount; ecount = 0; e_rv = 1;
    end
    raw_q.push_back(b);
    sv = raw_q.pop_front();
    sin_q.push_back(sv);
    if (sin_q.size() > GLITCH) void'(sin_q.pop_front());
    mf_prev = mf;
    if (sin_q.size() == GLITCH) begin
      flip = 1;
      foreach (sin_q[i]) if (sin_q[i] == mf) flip = 0;
      if (flip) mf = !mf;
    end
  endtask

  task automatic check_all();
    checks++;
    if (mif.high_time !== CNT_W'(e_high) || mif.low_time !== CNT_W'(e_low) ||
        mif.period !== (CNT_W+1)'(e_period) || mif.meas_valid !== e_mv ||
        mif.edge_rate !== RATE_W'(e_rate) || mif.rate_valid !== e_rv ||
        mif.stalled !== e_st || mif.stuck_level !== e_sl) begin
      errors++;
      $display("FAIL model t=%0t: high %0d/%0d low %0d/%0d period %0d/%0d mv %0b/%0b rate %0d/%0d rv %0b/%0b stalled %0b/%0b stuck %0b/%0b (got/expected)",
               $time, mif.high_time, e_high, mif.low_time, e_low, mif.period, e_period,
               mif.meas_valid, e_mv, mif.edge_rate, e_rate, mif.rate_valid, e_rv,
               mif.stalled, e_st, mif.stuck_level, e_sl);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive the pin, let the edge happen, compare at the falling edge.
  task automatic tick(input bit b);
    mif.blink_in = b;
    @(posedge clk);
    if (rst_n) model_edge(b);
    @(negedge clk);
    tk++;
    if (mif.meas_valid === 1'b1) mv_seen++;
    check_all();
  endtask

  task automatic seg(input bit b, input int len);
    repeat (len) tick(b);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    seg(1'b0, 4);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, first_stall, rv_cnt, last_rv;

    tbl[0] = '{hi: 10, lo: 30, reps: 4, exp_high: 10, exp_low: 30, exp_period: 40, exp_pulses: 4};
    tbl[1] = '{hi: 6,  lo: 9,  reps: 3, exp_high: 6,  exp_low: 9,  exp_period: 15, exp_pulses: 3};
    tbl[2] = '{hi: 25, lo: 5,  reps: 3, exp_high: 25, exp_low: 5,  exp_period: 30, exp_pulses: 3};
    tbl[3] = '{hi: 5,  lo: 6,  reps: 3, exp_high: 5,  exp_low: 6,  exp_period: 11, exp_pulses: 3};
    tbl[4] = '{hi: 100, lo: 40, reps: 2, exp_high: 100, exp_low: 40, exp_period: 140, exp_pulses: 2};

    mif.blink_in = 1'b0;
    model_reset();

    // Reset held while the pin toggles: everything stays at zero.
    for (int i = 0; i < 8; i++) tick(i[0]);
    chk("rst_high_time", int'(mif.high_time), 0);
    chk("rst_period", int'(mif.period), 0);
    rst_n = 1'b1;

    // First full cycle after reset is only the reference; nothing published.
    mv_seen = 0;
    seg(1'b0, 20); seg(1'b1, 10); seg(1'b0, 30);
    chk("first_cycle_pulses", mv_seen, 0);
    chk("first_cycle_high", int'(mif.high_time), 0);

    // Square-wave table.
    for (int v = 0; v < 5; v++) begin
      mv_seen = 0;
      for (int r = 0; r < tbl[v].reps; r++) begin
        seg(1'b1, tbl[v].hi);
        seg(1'b0, tbl[v].lo);
      end
      chk($sformatf("tbl%0d_high", v), int'(mif.high_time), tbl[v].exp_high);
      chk($sformatf("tbl%0d_low", v), int'(mif.low_time), tbl[v].exp_low);
      chk($sformatf("tbl%0d_period", v), int'(mif.period), tbl[v].exp_period);
      chk($sformatf("tbl%0d_pulses", v), mv_seen, tbl[v].exp_pulses);
    end

    // Glitch rejection: 3-sample pulse dropped, 4-sample pulse accepted.
    reset_dut();
    seg(1'b0, 20);
    mv_seen = 0;
    seg(1'b1, 3); seg(1'b0, 20);
    seg(1'b1, 4); seg(1'b0, 20);
    chk("glitch_no_pulse", mv_seen, 0);
    seg(1'b1, 10);
    chk("glitch_pulses", mv_seen, 1);
    chk("glitch_high", int'(mif.high_time), 4);
    chk("glitch_low", int'(mif.low_time), 20);
    chk("glitch_period", int'(mif.period), 24);

    // Stuck high: stall comes 2 sync + GLITCH filter + 1 FSM + TIMEOUT
    // cycles after the raw edge.
    seg(1'b0, 30);
    mv_seen = 0;
    t0 = tk;
    first_stall = -1;
    for (int i = 0; i < 600; i++) begin
      tick(1'b1);
      if (mif.stalled === 1'b1 && first_stall < 0) first_stall = tk - t0;
    end
    chk("stall_high_time", first_stall, GLITCH + 3 + TIMEOUT);
    chk("stall_high_level", int'(mif.stuck_level), 1);
    chk("stall_keeps_high", int'(mif.high_time), 10);
    chk("stall_keeps_low", int'(mif.low_time), 30);
    chk("stall_entry_pulses", mv_seen, 1);
    mv_seen = 0;
    seg(1'b0, 50); seg(1'b1, 20);
    chk("stall_cleared", int'(mif.stalled), 0);
    chk("stall_no_publish", mv_seen, 0);
    seg(1'b0, 30); seg(1'b1, 10);
    chk("after_stall_pulses", mv_seen, 1);
    chk("after_stall_high", int'(mif.high_time), 20);
    chk("after_stall_low", int'(mif.low_time), 30);

    // Stuck low.
    seg(1'b0, 520);
    chk("stall_low", int'(mif.stalled), 1);
    chk("stall_low_level", int'(mif.stuck_level), 0);
    mv_seen = 0;
    seg(1'b1, 10);
    chk("stall_low_cleared", int'(mif.stalled), 0);
    seg(1'b0, 30);
    chk("stall_low_no_publish", mv_seen, 0);
    seg(1'b1, 10);
    chk("after_low_stall_high", int'(mif.high_time), 10);
    chk("after_low_stall_low", int'(mif.low_time), 30);

    // Edge rate of a period-40 wave over three windows.
    reset_dut();
    rv_cnt = 0;
    last_rv = 0;
    for (int i = 0; i < 3120; i++) begin
      tick((i % 40) < 10);
      if (mif.rate_valid === 1'b1) begin
        rv_cnt++;
        if (rv_cnt == 1) begin
          chk("rate_first_in_range",
              int'(mif.edge_rate >= 24 && mif.edge_rate <= 26), 1);
        end else begin
          chk("rate_value", int'(mif.edge_rate), 25);
          chk("rate_interval", tk - last_rv, CLK_HZ);
        end
        last_rv = tk;
      end
    end
    chk("rate_windows", rv_cnt, 3);

    // Asynchronous reset in the middle of a high phase.
    seg(1'b1, 20);
    chk("pre_reset_high", int'(mif.high_time), 10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_high", int'(mif.high_time), 0);
    chk("async_rst_low", int'(mif.low_time), 0);
    chk("async_rst_period", int'(mif.period), 0);
    chk("async_rst_rate", int'(mif.edge_rate), 0);
    check_all();
    @(negedge clk);
    seg(1'b0, 5);
    rst_n = 1'b1;
    mv_seen = 0;
    seg(1'b0, 10); seg(1'b1, 10); seg(1'b0, 30);
    chk("post_rst_no_publish", mv_seen, 0);
    seg(1'b1, 10);
    chk("post_rst_pulses", mv_seen, 1);
    chk("post_rst_high", int'(mif.high_time), 10);
    chk("post_rst_low", int'(mif.low_time), 30);

    // Random pulse trains, including glitches and near-timeout gaps.
    for (int s = 0; s < 60; s++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r < 7)      len = $urandom_range(1, 20);
      else if (r < 9) len = $urandom_range(20, 80);
      else            len = $urandom_range(480, 560);
      seg((s % 2) == 0, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
